retro_comm_initiator: RTL and testbench

//   Host-side transmitter for the RetroComm command link; drives the console's RetroComm target

---
 rtl/retro_comm_initiator.sv | 160 ++++++++++++++++
 tb/tb_retro_comm_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retro_comm_initiator.sv
// RetroComm host-side initiator: frames a host command as header/payload/checksum bytes and
// retransmits on NAK or response timeout until ACKed or the retry budget is spent.
module retro_comm_initiator #(
    parameter int unsigned MAX_PAYLOAD = 8,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [3:0]               cmd_len,
    input  logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               status
);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1) + 1;

    localparam logic [7:0] AckByte = 8'hA5;
    localparam logic [7:0] NakByte = 8'h5A;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatNak     = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;
    localparam logic [1:0] StatBadLen  = 2'b11;

    typedef enum logic [2:0] {StIdle, StHeader, StPayload, StChecksum, StWaitAck} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               op_q, len_q, idx_q;
    logic [8*MAX_PAYLOAD-1:0] payload_q;
    logic [7:0]               sum_q, cur_byte;
    logic [TW-1:0]            timer_q;
    logic [RW-1:0]            retry_q;
    logic                     done_q, error_q;
    logic [1:0]               status_q;

    logic accept, len_bad, hs, rx_ack, rx_nak, expired, can_retry, last_byte, enter_header;

    assign accept       = cmd_valid && (state_q == StIdle);
    assign len_bad      = 32'(cmd_len) > MAX_PAYLOAD;
    assign hs           = tx_valid && tx_ready;
    assign rx_ack       = rx_valid && (rx_data == AckByte);
    assign rx_nak       = rx_valid && (rx_data == NakByte);
    assign expired      = timer_q == TW'(TIMEOUT - 1);
    assign can_retry    = retry_q < RW'(MAX_RETRIES);
    assign last_byte    = (idx_q + 4'd1) == len_q;
    assign enter_header = (state_d == StHeader) && (state_q != StHeader);

    always_comb begin
        cur_byte = '0;
        for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
            if (idx_q == 4'(i)) cur_byte = payload_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (accept && !len_bad) state_d = StHeader;
            StHeader:   if (hs) state_d = (len_q != 4'd0) ? StPayload : StChecksum;
            StPayload:  if (hs && last_byte) state_d = StChecksum;
            StChecksum: if (hs) state_d = StWaitAck;
            StWaitAck: begin
                // A response on the expiry cycle wins over the timeout.
                if (rx_ack)                  state_d = StIdle;
                else if (rx_nak || expired)  state_d = can_retry ? StHeader : StIdle;
            end
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            len_q     <= '0;
            payload_q <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            status_q  <= StatOk;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (accept) begin
                op_q      <= cmd_op;
                len_q     <= cmd_len;
                payload_q <= cmd_payload;
                retry_q   <= '0;
                if (len_bad) begin
                    error_q  <= 1'b1;
                    status_q <= StatBadLen;
                end
            end
            if (enter_header) begin
                idx_q <= '0;
                sum_q <= (state_q == StIdle) ? {cmd_op, cmd_len} : {op_q, len_q};
            end
            if (state_q == StWaitAck && state_d == StHeader) retry_q <= retry_q + RW'(1);
            if (state_q == StPayload && hs) begin
                idx_q <= idx_q + 4'd1;
                sum_q <= sum_q + cur_byte;
            end
            if (state_q == StChecksum && hs) timer_q <= '0;
            else if (state_q == StWaitAck)   timer_q <= timer_q + TW'(1);
            if (state_q == StWaitAck) begin
                if (rx_ack) begin
                    done_q   <= 1'b1;
                    status_q <= StatOk;
                end else if ((rx_nak || expired) && !can_retry) begin
                    error_q  <= 1'b1;
                    status_q <= rx_nak ? StatNak : StatTimeout;
                end
            end
        end
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        tx_valid  = 1'b0;
        tx_data   = '0;
        done      = done_q;
        error     = error_q;
        status    = status_q;
        unique case (state_q)
            StHeader: begin
                tx_valid = 1'b1;
                tx_data  = {op_q, len_q};
            end
            StPayload: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
            end
            StChecksum: begin
                tx_valid = 1'b1;
                tx_data  = 8'd0 - sum_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_retro_comm_initiator.sv
// Directed bench for retro_comm_initiator: a packet-level model checks every transmitted byte,
// handshake stability and the done/error/status outcome of each scenario.
module tb_retro_comm_initiator;
    localparam int unsigned MAXP = 8;
    localparam int unsigned TMO  = 16;
    localparam int unsigned RETR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid, cmd_ready;
    logic [3:0]      cmd_op, cmd_len;
    logic [8*MAXP-1:0] cmd_payload;
    logic [7:0]      tx_data;
    logic            tx_valid, tx_ready;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            busy, done, error;
    logic [1:0]      status;

    always #5 clk = ~clk;

    retro_comm_initiator #(
        .MAX_PAYLOAD(MAXP),
        .TIMEOUT    (TMO),
        .MAX_RETRIES(RETR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_payload(cmd_payload),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .status     (status)
    );

    int nvec = 0;
    int nmis = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Packet model: expected link bytes of the current command, written by the stimulus.
    logic [7:0] pkt [0:MAXP+1];
    int         pkt_len = 0;
    int         cmd_seq = 0;
    // Observed link bytes and completed transmissions, written by the compare process.
    logic [7:0] cap [$];
    int         pkts = 0;

    bit fixed_ready = 1'b1;
    bit rand_mode   = 1'b0;

    initial begin : ready_drv
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_mode ? ($urandom_range(0, 1) == 1) : fixed_ready;
        end
    end

    initial begin : compare
        int         idx;
        int         seen;
        bit         pend;
        logic [7:0] pend_d;
        idx = 0; seen = 0; pend = 1'b0; pend_d = '0;
        forever begin
            @(negedge clk);
            if (seen != cmd_seq) begin
                seen = cmd_seq;
                idx  = 0;
                pkts = 0;
                cap.delete();
            end
            if (!rst_n) begin
                idx  = 0;
                pend = 1'b0;
            end else begin
                check("ready_vs_busy", 32'(busy), 32'(!cmd_ready));
                check("done_error_excl", 32'(done && error), 0);
                if (pend) begin
                    check("hold_valid", 32'(tx_valid), 1);
                    check("hold_data", 32'(tx_data), 32'(pend_d));
                end
                if (pkt_len == 0) begin
                    check("no_tx_expected", 32'(tx_valid), 0);
                end else if (tx_valid && tx_ready) begin
                    check("tx_byte", 32'(tx_data), 32'(pkt[idx]));
                    cap.push_back(tx_data);
                    idx++;
                    if (idx == pkt_len) begin
                        idx = 0;
                        pkts++;
                    end
                end
                pend   = tx_valid && !tx_ready;
                pend_d = tx_data;
            end
        end
    end

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] len, input logic [63:0] pl);
        logic [7:0] s;
        cmd_seq++;
        if (int'(len) > int'(MAXP)) begin
            pkt_len = 0;
        end else begin
            pkt[0] = {op, len};
            s      = pkt[0];
            for (int i = 0; i < int'(len); i++) begin
                pkt[i+1] = pl[8*i +: 8];
                s        = s + pkt[i+1];
            end
            pkt[int'(len)+1] = -s;
            pkt_len          = int'(len) + 2;
        end
        @(posedge clk);
        #1;
        cmd_op      = op;
        cmd_len     = len;
        cmd_payload = pl;
        cmd_valid   = 1'b1;
        @(negedge clk);
        check("cmd_ready_at_accept", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        if (pkt_len > 0) check("first_tx_latency", 32'(tx_valid), 1);
    endtask

    task automatic wait_pkts(input int n, input string name);
        int k;
        k = 0;
        while (pkts < n && k < 300) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 32'(pkts), 32'(n));
    endtask

    // Present one response byte; returns at the first sample after the DUT has seen it.
    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        int gap;
        int k;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_len     = '0;
        cmd_payload = '0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_status", 32'(status), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty packet, ACK three cycles after the checksum.
        run_cmd(4'd1, 4'd0, 64'h0);
        check("t1_model_hdr", 32'(pkt[0]), 32'h10);
        check("t1_model_csum", 32'(pkt[1]), 32'hF0);
        wait_pkts(1, "t1_pkts");
        check("t1_ncap", 32'(cap.size()), 2);
        check("t1_b0", 32'(cap[0]), 32'h10);
        check("t1_b1", 32'(cap[1]), 32'hF0);
        repeat (3) @(posedge clk);
        send_rx(8'hA5);
        check("t1_done", 32'(done), 1);
        check("t1_error", 32'(error), 0);
        check("t1_status", 32'(status), 0);
        check("t1_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        #1;
        check("t1_done_pulse", 32'(done), 0);

        // Two payload bytes under random backpressure.
        rand_mode = 1'b1;
        run_cmd(4'd2, 4'd2, 64'h1234);
        check("t2_model_b2", 32'(pkt[2]), 32'h12);
        check("t2_model_csum", 32'(pkt[3]), 32'h98);
        wait_pkts(1, "t2_pkts");
        rand_mode = 1'b0;
        check("t2_ncap", 32'(cap.size()), 4);
        check("t2_b0", 32'(cap[0]), 32'h22);
        check("t2_b1", 32'(cap[1]), 32'h34);
        check("t2_b2", 32'(cap[2]), 32'h12);
        check("t2_b3", 32'(cap[3]), 32'h98);
        send_rx(8'hA5);
        check("t2_done", 32'(done), 1);

        // NAK once, then ACK: identical resend.
        run_cmd(4'd2, 4'd2, 64'h1234);
        wait_pkts(1, "t3_pkts1");
        send_rx(8'h5A);
        check("t3_no_done", 32'(done), 0);
        check("t3_no_error", 32'(error), 0);
        wait_pkts(2, "t3_pkts2");
        check("t3_ncap", 32'(cap.size()), 8);
        check("t3_resend_csum", 32'(cap[7]), 32'h98);
        send_rx(8'hA5);
        check("t3_done", 32'(done), 1);
        check("t3_status", 32'(status), 0);

        // Silent console: three attempts, 16 idle cycles each, then timeout error.
        run_cmd(4'd3, 4'd1, 64'h77);
        for (int a = 1; a <= 3; a++) begin
            wait_pkts(a, "t4_pkts");
            @(negedge clk);
            #1;
            gap = 0;
            while (!tx_valid && !error && gap < 100) begin
                gap++;
                @(negedge clk);
                #1;
            end
            check("t4_gap", 32'(gap), 16);
        end
        check("t4_error", 32'(error), 1);
        check("t4_status", 32'(status), 2);
        repeat (20) @(negedge clk);
        #2;
        check("t4_total_pkts", 32'(pkts), 3);

        // NAKs only: error with NAK status after the third attempt.
        run_cmd(4'd3, 4'd1, 64'h77);
        for (int a = 1; a <= 3; a++) begin
            wait_pkts(a, "t5_pkts");
            send_rx(8'h5A);
            check("t5_error", 32'(error), (a == 3) ? 1 : 0);
        end
        check("t5_status", 32'(status), 1);
        repeat (5) @(negedge clk);
        #2;
        check("t5_status_hold", 32'(status), 1);
        check("t5_total_pkts", 32'(pkts), 3);

        // Oversize length: nothing sent, bad-length error.
        run_cmd(4'd4, 4'd9, 64'h0);
        check("t6_error", 32'(error), 1);
        check("t6_status", 32'(status), 3);
        check("t6_cmd_ready", 32'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        #1;
        check("t6_cmd_ready_idle", 32'(cmd_ready), 1);
        check("t6_ncap", 32'(cap.size()), 0);

        // Reset while the second payload byte is pending.
        fixed_ready = 1'b1;
        run_cmd(4'd2, 4'd2, 64'h1234);
        k = 0;
        while (cap.size() < 2 && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        fixed_ready = 1'b0;
        @(negedge clk);
        #1;
        check("t7_pending_valid", 32'(tx_valid), 1);
        check("t7_pending_data", 32'(tx_data), 32'h12);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_async_valid", 32'(tx_valid), 0);
        check("t7_async_busy", 32'(busy), 0);
        check("t7_async_ready", 32'(cmd_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        fixed_ready = 1'b1;
        run_cmd(4'd1, 4'd0, 64'h0);
        wait_pkts(1, "t7_pkts");
        check("t7_ncap", 32'(cap.size()), 2);
        check("t7_b0", 32'(cap[0]), 32'h10);
        check("t7_b1", 32'(cap[1]), 32'hF0);
        send_rx(8'hA5);
        check("t7_done", 32'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
